// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings presented on md_unit.op by the EX stage
//   - FSM state encodings for md_unit
//   - small elaboration-time helpers
package md_unit_pkg;

    // Operation encodings (3-bit op bus). Encoding 7 is treated as NONE.
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the divide ops (they use DIV_CYCLES as latency).
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// md_calc: purely combinational arithmetic for the multiply/divide unit.
// Ports:
//   op      in  3      operation (MD_* encoding)
//   a       in  WIDTH  rs operand (multiplicand / dividend)
//   b       in  WIDTH  rt operand (multiplier / divisor)
//   res_hi  out WIDTH  value destined for HI
//   res_lo  out WIDTH  value destined for LO
//   res_wr  out 1      1 when HI/LO should be written at commit
//                      (0 for non-arithmetic ops and for divide by zero)
module md_calc
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_wr
);

    // Multiplication: extend both operands to 2*WIDTH; the low 2*WIDTH bits
    // of the product of the extended values are the exact full product.
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u;

    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx   = {{WIDTH{1'b0}}, a};
    assign b_zx   = {{WIDTH{1'b0}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Division: one unsigned divider shared by DIV and DIVU. For DIV the
    // operands are converted to magnitudes and signs are restored afterwards.
    // The most-negative dividend has magnitude 2^(WIDTH-1), which still fits
    // in WIDTH unsigned bits, so -2^(WIDTH-1) / -1 naturally yields
    // quotient -2^(WIDTH-1) (wrapped) and remainder 0 with no special case.
    logic             div_signed;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a, mag_b, safe_b;
    logic [WIDTH-1:0] quo_u, rem_u;
    logic [WIDTH-1:0] quo_s, rem_s;

    assign div_signed = (op == MD_DIV);
    assign b_zero     = (b == '0);
    assign mag_a      = (div_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b      = (div_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    // Keep the divider away from a zero divisor; the result is discarded.
    assign safe_b     = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign quo_u      = mag_a / safe_b;
    assign rem_u      = mag_a % safe_b;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign quo_s      = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~quo_u + 1'b1) : quo_u;
    assign rem_s      = a[WIDTH-1] ? (~rem_u + 1'b1) : rem_u;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
                res_wr = 1'b1;
            end
            MD_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
                res_wr = 1'b1;
            end
            MD_DIV: begin
                res_hi = rem_s;
                res_lo = quo_s;
                res_wr = !b_zero;
            end
            MD_DIVU: begin
                res_hi = rem_u;
                res_lo = quo_u;
                res_wr = !b_zero;
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
                res_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// The result is computed combinationally at issue and held in pending
// registers; the latency counter only models the occupancy seen by the
// hazard unit, and HI/LO are updated on the last busy edge.
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous active-high reset, clears all state
//   start  in  1      issue pulse (only meaningful for MULT/MULTU/DIV/DIVU)
//   op     in  3      operation (MD_* encoding)
//   a      in  WIDTH  rs operand
//   b      in  WIDTH  rt operand
//   busy   out 1      high while a multiply/divide is in flight
//   hi     out WIDTH  HI register
//   lo     out WIDTH  LO register
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = max_int(MULT_CYCLES, DIV_CYCLES);
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [0:0]       state_reg,   state_next;
    logic [CW-1:0]    count_reg,   count_next;
    logic [WIDTH-1:0] pend_hi_reg, pend_hi_next;
    logic [WIDTH-1:0] pend_lo_reg, pend_lo_next;
    logic             pend_wr_reg, pend_wr_next;
    logic [WIDTH-1:0] hi_reg,      hi_next;
    logic [WIDTH-1:0] lo_reg,      lo_next;

    logic [WIDTH-1:0] calc_hi, calc_lo;
    logic             calc_wr;

    md_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (calc_hi),
        .res_lo (calc_lo),
        .res_wr (calc_wr)
    );

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_wr_next = pend_wr_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && is_md_op(op)) begin
                    state_next   = ST_RUN;
                    count_next   = is_div_op(op) ? DIV_N : MULT_N;
                    pend_hi_next = calc_hi;
                    pend_lo_next = calc_lo;
                    pend_wr_next = calc_wr;
                end else if (op == MD_MTHI) begin
                    hi_next = a;
                end else if (op == MD_MTLO) begin
                    lo_next = a;
                end
            end
            ST_RUN: begin
                // start and MTHI/MTLO are ignored while running.
                if (count_reg == ONE) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    if (pend_wr_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                end else begin
                    count_next = count_reg - ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            pend_wr_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_wr_reg <= pend_wr_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    // busy is the RUN state flop itself, so it is glitch-free and registered.
    assign busy = (state_reg == ST_RUN);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of directed vectors plus
// hand-written sequences for MTHI/MTLO, MTHI during RUN and mid-op reset.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    // Bench model of the architectural HI/LO contents.
    logic [WIDTH-1:0] model_hi;
    logic [WIDTH-1:0] model_lo;

    typedef struct {
        logic             start;
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_hi;
        logic [WIDTH-1:0] exp_lo;
        int               cycles;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    md_unit #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard unit must never issue while busy.
    always @(posedge clk) begin
        if (!reset && busy && start && is_md_op(op))
            $error("start asserted while busy");
    end

    task automatic check32(input string name, input logic [WIDTH-1:0] act,
                           input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one vector at a falling edge, count busy cycles, compare results.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        start = v.start; op = v.op; a = v.a; b = v.b;
        @(negedge clk);
        start = 1'b0; op = MD_NONE; a = '0; b = '0;
        if (busy) begin
            check32($sformatf("v%0d early_hi", idx), hi, model_hi);
            check32($sformatf("v%0d early_lo", idx), lo, model_lo);
        end
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_int($sformatf("v%0d busy_cycles", idx), n, v.cycles);
        check32($sformatf("v%0d hi", idx), hi, v.exp_hi);
        check32($sformatf("v%0d lo", idx), lo, v.exp_lo);
        model_hi = v.exp_hi;
        model_lo = v.exp_lo;
        $display("vec %0d op=%0d a=%h b=%h busy=%0d hi=%h lo=%h",
                 idx, v.op, v.a, v.b, n, hi, lo);
    endtask

    initial begin
        int  n;
        logic seen_busy;

        //              start op        a             b             exp_hi        exp_lo        cyc
        vecs[0]  = '{1'b1, MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[1]  = '{1'b1, MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{1'b1, MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{1'b1, MD_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{1'b1, MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{1'b1, MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[6]  = '{1'b1, MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[7]  = '{1'b1, MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8]  = '{1'b1, MD_DIV,   32'd5,        32'd0,        32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9]  = '{1'b1, MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};
        vecs[10] = '{1'b1, MD_NONE,  32'd5,        32'd5,        32'h00000001, 32'h23456780, 0};
        vecs[11] = '{1'b1, 3'd7,     32'd5,        32'd5,        32'h00000001, 32'h23456780, 0};
        vecs[12] = '{1'b0, MD_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'h23456780, 0};
        vecs[13] = '{1'b1, MD_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};
        vecs[14] = '{1'b1, MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10};

        reset = 1'b1; start = 1'b0; op = MD_NONE; a = '0; b = '0;
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        @(negedge clk);
        check_int("reset busy", int'(busy), 0);
        check32("reset hi", hi, '0);
        check32("reset lo", lo, '0);
        reset = 1'b0;
        $display("reset released busy=%0d hi=%h lo=%h", busy, hi, lo);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Back-to-back MTHI then MTLO; busy must never rise.
        seen_busy = 1'b0;
        @(negedge clk);
        op = MD_MTHI; a = 32'hAAAA0001;
        @(negedge clk);
        seen_busy |= busy;
        op = MD_MTLO; a = 32'hBBBB0002;
        @(negedge clk);
        seen_busy |= busy;
        op = MD_NONE; a = '0;
        @(negedge clk);
        seen_busy |= busy;
        check_int("mt b2b busy", int'(seen_busy), 0);
        check32("mt b2b hi", hi, 32'hAAAA0001);
        check32("mt b2b lo", lo, 32'hBBBB0002);
        $display("mthi/mtlo back-to-back hi=%h lo=%h", hi, lo);

        // MTHI issued while RUN is ignored.
        @(negedge clk);
        start = 1'b1; op = MD_MULTU; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = MD_MTHI; a = 32'hDEADBEEF; b = '0;
        @(negedge clk);
        op = MD_NONE; a = '0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_int("mthi_in_run cycles", n, 4);
        check32("mthi_in_run hi", hi, 32'h0);
        check32("mthi_in_run lo", lo, 32'd42);
        $display("mthi during run hi=%h lo=%h", hi, lo);

        // Reset in the third busy cycle of a MULT.
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0; op = MD_NONE; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_int("midreset busy", int'(busy), 0);
        check32("midreset hi", hi, '0);
        check32("midreset lo", lo, '0);
        @(negedge clk);
        reset = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        check_int("post reset busy", int'(seen_busy), 0);
        check32("post reset hi", hi, '0);
        check32("post reset lo", lo, '0);
        $display("reset mid-mult busy=%0d hi=%h lo=%h", seen_busy, hi, lo);
        model_hi = '0; model_lo = '0;
        run_vec('{1'b1, MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 5}, 99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
